mux_rr_arbiter: RTL and testbench

//  Shares one 4:1 select datapath between four requesters using round-robin arbitration.

---
 rtl/mux_rr_arbiter_pkg.sv | 18 +
 rtl/mux_rr_arbiter_if.sv | 34 +++
 rtl/mux_rr_arbiter_rr_pick.sv | 30 +++
 rtl/mux_rr_arbiter.sv | 144 ++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
//   arb_state_t    : arbiter FSM states (IDLE, GRANT)
//   NREQ           : number of requesters sharing the mux
//   req_idx_t      : requester index / mux select
//   idx_to_onehot  : converts a requester index into a one-hot grant vector
package mux_arb_pkg;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;

  localparam int NREQ = 4;

  typedef logic [1:0] req_idx_t;

  function automatic logic [NREQ-1:0] idx_to_onehot(input req_idx_t idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Request/grant/data bundle between the requesters and the arbiter.
//   req      : per-requester request, held high until done
//   i0..i3   : per-requester data
//   gnt      : one-hot grant (zero when idle)
//   s        : mux select, index of the granted requester
//   o        : registered mux output
//   o_valid  : o carries data from a granted, still-requesting cycle
//   busy     : arbiter is in the GRANT state
// master = requester side, slave = arbiter side.
interface mux_rr_arbiter_if #(parameter int WIDTH = 1);
  import mux_arb_pkg::*;

  logic [NREQ-1:0]  req;
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic [WIDTH-1:0] i2;
  logic [WIDTH-1:0] i3;
  logic [NREQ-1:0]  gnt;
  req_idx_t         s;
  logic [WIDTH-1:0] o;
  logic             o_valid;
  logic             busy;

  modport master (
    output req, i0, i1, i2, i3,
    input  gnt, s, o, o_valid, busy
  );

  modport slave (
    input  req, i0, i1, i2, i3,
    output gnt, s, o, o_valid, busy
  );

endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational rotate-priority encoder.
//   req   : candidate mask
//   last  : most recently served index; the scan starts at last+1 and wraps
//   found : at least one candidate bit is set
//   idx   : first set candidate in rotation order (last when none found)
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  req_idx_t        last,
  output logic            found,
  output req_idx_t        idx
);

  req_idx_t pos_s;

  // Walk the rotation from farthest to nearest so the nearest set bit wins;
  // offset NREQ truncates to 0, i.e. last itself is considered last of all.
  always_comb begin
    found = 1'b0;
    idx   = last;
    pos_s = last;
    for (int k = NREQ; k >= 1; k--) begin
      pos_s = last + req_idx_t'(k);
      found = found | req[pos_s];
      idx   = req[pos_s] ? pos_s : idx;
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of a shared 4:1 mux select with a hold limit.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of mux_rr_arbiter_if (req, i0..i3 in; gnt, s, o,
//          o_valid, busy out)
// An owner keeps the mux while it requests, but after MAX_HOLD consecutive
// cycles it is preempted if anybody else is waiting. Handover to the next
// requester happens at the same edge as the release/preempt (no idle bubble).
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  mux_rr_arbiter_if.slave   bus
);

  localparam int            HW        = $clog2(MAX_HOLD) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  arb_state_t       state_r, state_s;
  logic [HW-1:0]    hold_r, hold_s;
  req_idx_t         last_r, last_s;
  req_idx_t         s_r, s_s;
  logic [NREQ-1:0]  gnt_r, gnt_s;
  logic [WIDTH-1:0] o_r;
  logic             o_valid_r;

  logic             owner_req_s;
  logic             release_s;
  logic             preempt_s;
  logic [NREQ-1:0]  waiting_s;
  logic [NREQ-1:0]  cand_s;
  logic             found_s;
  req_idx_t         win_s;
  logic [WIDTH-1:0] sel_s;

  assign owner_req_s = bus.req[s_r];
  assign waiting_s   = bus.req & ~gnt_r;
  assign release_s   = (state_r == GRANT) && !owner_req_s;
  assign preempt_s   = (state_r == GRANT) && owner_req_s &&
                       (hold_r == HOLD_LAST) && (waiting_s != 4'b0000);
  // A preempted owner is excluded so it cannot immediately win itself back.
  assign cand_s      = ((state_r == IDLE) || release_s) ? bus.req : waiting_s;

  // last_r equals s_r while granted, so it doubles as the scan origin k.
  rr_pick u_pick (
    .req   (cand_s),
    .last  (last_r),
    .found (found_s),
    .idx   (win_s)
  );

  // Select the data of the current owner.
  always_comb begin
    sel_s = bus.i0;
    case (s_r)
      2'd0:    sel_s = bus.i0;
      2'd1:    sel_s = bus.i1;
      2'd2:    sel_s = bus.i2;
      2'd3:    sel_s = bus.i3;
      default: sel_s = bus.i0;
    endcase
  end

  // Next-state, grant and hold-counter logic.
  always_comb begin
    state_s = state_r;
    hold_s  = hold_r;
    last_s  = last_r;
    s_s     = s_r;
    gnt_s   = gnt_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_s = GRANT;
          gnt_s   = idx_to_onehot(win_s);
          s_s     = win_s;
          last_s  = win_s;
          hold_s  = '0;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        if (release_s || preempt_s) begin
          hold_s = '0;
          if (found_s) begin
            gnt_s  = idx_to_onehot(win_s);
            s_s    = win_s;
            last_s = win_s;
          end else begin
            state_s = IDLE;
            gnt_s   = 4'b0000;
          end
        end else if (hold_r != HOLD_LAST) begin
          hold_s = hold_r + HW'(1);
        end else begin
          // Saturate while nobody else is waiting.
          hold_s = hold_r;
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = 4'b0000;
        hold_s  = '0;
      end
    endcase
  end

  // State, grant and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      hold_r    <= '0;
      last_r    <= 2'd3;
      s_r       <= 2'd0;
      gnt_r     <= 4'b0000;
      o_r       <= '0;
      o_valid_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      hold_r    <= hold_s;
      last_r    <= last_s;
      s_r       <= s_s;
      gnt_r     <= gnt_s;
      o_valid_r <= (state_r == GRANT) && owner_req_s;
      if ((state_r == GRANT) && owner_req_s) begin
        o_r <= sel_s;
      end else begin
        o_r <= o_r;
      end
    end
  end

  assign bus.gnt     = gnt_r;
  assign bus.s       = s_r;
  assign bus.o       = o_r;
  assign bus.o_valid = o_valid_r;
  assign bus.busy    = (state_r == GRANT);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed steps plus a short random
// phase. A behavioural model predicts each cycle's outputs into a queue when
// the stimulus is applied; the entry is popped and compared after the edge.
module tb_mux_rr_arbiter;
  import mux_arb_pkg::*;

  localparam int WIDTH    = 4;
  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

  logic [WIDTH-1:0] din [4];
  assign bus.i0 = din[0];
  assign bus.i1 = din[1];
  assign bus.i2 = din[2];
  assign bus.i3 = din[3];

  mux_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [3:0]       gnt;
    logic [1:0]       s;
    logic [WIDTH-1:0] o;
    logic             ov;
    logic             busy;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // model state
  logic             m_busy;
  int               m_hold;
  int               m_last;
  int               m_s;
  logic [3:0]       m_gnt;
  logic [WIDTH-1:0] m_o;
  logic             m_ov;

  function automatic int pick(input logic [3:0] c, input int from);
    for (int off = 0; off < 4; off++) begin
      if (c[(from + off) % 4]) return (from + off) % 4;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge using the currently driven inputs.
  task automatic model_step();
    logic [3:0] r;
    logic [3:0] wait_m;
    logic       rel;
    logic       pre;
    int         w;
    r = bus.req;
    if (rst) begin
      m_busy = 1'b0; m_hold = 0; m_last = 3; m_s = 0;
      m_gnt = 4'b0000; m_o = '0; m_ov = 1'b0;
    end else begin
      m_ov = m_busy && r[m_s];
      if (m_ov) m_o = din[m_s];
      if (!m_busy) begin
        w = pick(r, m_last + 1);
        if (w >= 0) begin
          m_busy = 1'b1; m_gnt = 4'b0001 << w; m_s = w; m_last = w; m_hold = 0;
        end
      end else begin
        rel    = !r[m_s];
        wait_m = r & ~m_gnt;
        pre    = !rel && (m_hold == MAX_HOLD - 1) && (wait_m != 4'b0000);
        if (rel || pre) begin
          w = pick(rel ? r : wait_m, m_s + 1);
          m_hold = 0;
          if (w >= 0) begin
            m_gnt = 4'b0001 << w; m_s = w; m_last = w;
          end else begin
            m_busy = 1'b0; m_gnt = 4'b0000;
          end
        end else if (m_hold < MAX_HOLD - 1) begin
          m_hold++;
        end
      end
    end
  endtask

  // Predict, clock once, then compare the popped prediction with the DUT.
  task automatic cycle(input string tag);
    exp_t e;
    model_step();
    e.gnt = m_gnt; e.s = 2'(m_s); e.o = m_o; e.ov = m_ov; e.busy = m_busy;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check({tag, ".gnt"},     bus.gnt,     e.gnt);
    check({tag, ".s"},       bus.s,       e.s);
    check({tag, ".o"},       bus.o,       e.o);
    check({tag, ".o_valid"}, bus.o_valid, e.ov);
    check({tag, ".busy"},    bus.busy,    e.busy);
  endtask

  logic [3:0] eg;

  initial begin
    // 1: reset with all requests high
    rst = 1'b1; bus.req = 4'hF;
    din[0] = 4'h5; din[1] = 4'h6; din[2] = 4'h1; din[3] = 4'h9;
    for (int n = 0; n < 2; n++) begin
      cycle("rst");
      check("rst.gnt0", bus.gnt, 4'b0000);
      check("rst.ov0", bus.o_valid, 1'b0);
    end

    // 2: single requester 2, held then dropped
    rst = 1'b0; bus.req = 4'b0100;
    cycle("t2");
    check("t2.gnt_c1", bus.gnt, 4'b0100);
    check("t2.ov_c1", bus.o_valid, 1'b0);
    for (int n = 0; n < 3; n++) begin
      cycle("t2h");
      check("t2.ov", bus.o_valid, 1'b1);
      check("t2.o", bus.o, 4'h1);
    end
    bus.req = 4'b0000;
    cycle("t2d");
    check("t2.gnt_idle", bus.gnt, 4'b0000);
    check("t2.s_keep", bus.s, 2'd2);
    cycle("t2i");

    // 3: all requesting -> 0,1,2,3,0 each for MAX_HOLD cycles
    rst = 1'b1; cycle("t3r");
    rst = 1'b0; bus.req = 4'b1111;
    for (int n = 1; n <= 20; n++) begin
      cycle("t3");
      eg = 4'b0001 << (((n - 1) / MAX_HOLD) % 4);
      check("t3.order", bus.gnt, eg);
    end

    // 4: owner 1 preempted by 3, then regranted
    rst = 1'b1; bus.req = 4'b0000; cycle("t4r");
    rst = 1'b0; bus.req = 4'b0010;
    cycle("t4");
    check("t4.gnt1", bus.gnt, 4'b0010);
    bus.req = 4'b1010;
    for (int n = 0; n < 3; n++) cycle("t4h");
    check("t4.still1", bus.gnt, 4'b0010);
    cycle("t4p");
    check("t4.pre3", bus.gnt, 4'b1000);
    for (int n = 0; n < 3; n++) cycle("t4h3");
    cycle("t4b");
    check("t4.back1", bus.gnt, 4'b0010);

    // 5: owner 3 drops while 0 rises -> direct wrap handover
    rst = 1'b1; bus.req = 4'b0000; cycle("t5r");
    rst = 1'b0; bus.req = 4'b1000;
    cycle("t5");
    check("t5.gnt3", bus.gnt, 4'b1000);
    bus.req = 4'b0001;
    cycle("t5w");
    check("t5.gnt0", bus.gnt, 4'b0001);
    check("t5.busy", bus.busy, 1'b1);

    // 6: reset mid-grant
    rst = 1'b1; bus.req = 4'b0000; cycle("t6r");
    rst = 1'b0; bus.req = 4'b0010; din[1] = 4'hA;
    cycle("t6g");
    cycle("t6v");
    check("t6.ov", bus.o_valid, 1'b1);
    check("t6.o", bus.o, 4'hA);
    rst = 1'b1; bus.req = 4'b0011;
    cycle("t6x");
    check("t6.gnt", bus.gnt, 4'b0000);
    check("t6.o0", bus.o, 4'h0);
    check("t6.ov0", bus.o_valid, 1'b0);
    rst = 1'b0;
    cycle("t6a");
    check("t6.first0", bus.gnt, 4'b0001);

    // random traffic
    for (int n = 0; n < 80; n++) begin
      rst     = ($urandom_range(0, 40) == 0);
      bus.req = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) din[k] = WIDTH'($urandom_range(0, 15));
      cycle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
